// File: rtl/ftoi_pipe.sv
// ftoi_pipe: 3-stage binary32 -> OUT_W-bit signed/unsigned integer converter with valid/ready handshake.
// Define FTOI_FLAGS_EN to produce NV/NX flags; without it out_flags is tied to 2'b00.
module ftoi_pipe #(
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [2:0]       in_rm,
    input  logic             in_unsigned,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic [1:0]       out_flags,
    output logic [TAG_W-1:0] out_tag
);
    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    // acc holds the significand as fixed point with 25 fraction bits
    localparam int                AW       = OUT_W + 26;
    localparam logic [7:0]        BIG_E    = 8'(128 + OUT_W);
    localparam logic [OUT_W+1:0]  SMIN_MAG = (OUT_W+2)'(1) << (OUT_W - 1);
    localparam logic [OUT_W+1:0]  SMAX_MAG = SMIN_MAG - (OUT_W+2)'(1);
    localparam logic [OUT_W+1:0]  UMAX_MAG = {2'b00, {OUT_W{1'b1}}};

    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // S1 decode / align
    logic             sign_d;
    logic [7:0]       e_d;
    logic [22:0]      m_d;
    logic [AW-1:0]    acc;
    logic [OUT_W:0]   int_d;
    logic             g_d, st_d, big_d, nan_d;

    assign sign_d = in_x[31];
    assign e_d    = in_x[30:23];
    assign m_d    = in_x[22:0];

    always_comb begin
        acc   = AW'({1'b1, m_d}) << (e_d - 8'd125);
        int_d = '0;
        g_d   = 1'b0;
        st_d  = 1'b0;
        big_d = (e_d >= BIG_E);
        nan_d = (e_d == 8'hFF) && (m_d != '0);
        if (!big_d) begin
            if (e_d >= 8'd126) begin
                int_d = acc[AW-1:25];
                g_d   = acc[24];
                st_d  = |acc[23:0];
            end else begin
                st_d  = |in_x[30:0];
            end
        end
    end

    logic             s1_v, s1_sign, s1_g, s1_st, s1_uns, s1_nan, s1_big;
    logic [OUT_W:0]   s1_int;
    logic [2:0]       s1_rm;
    logic [TAG_W-1:0] s1_tag;

    // S2 round / add
    logic             inc;
    logic [OUT_W+1:0] mag_d;

    always_comb begin
        inc = 1'b0;
        case (s1_rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s1_sign & (s1_g | s1_st);
            RM_RUP:  inc = ~s1_sign & (s1_g | s1_st);
            RM_RMM:  inc = s1_g;
            default: inc = s1_g & (s1_st | s1_int[0]);
        endcase
        mag_d = {1'b0, s1_int} + (OUT_W+2)'(inc);
    end

    logic             s2_v, s2_sign, s2_uns, s2_nan, s2_big;
    logic [OUT_W+1:0] s2_mag;
    logic [TAG_W-1:0] s2_tag;

    // S3 saturate / negate
    logic             ovf, uneg;
    logic [OUT_W-1:0] mag_lo, pos_max, neg_min, y_d;

    always_comb begin
        mag_lo  = s2_mag[OUT_W-1:0];
        pos_max = s2_uns ? '1 : {1'b0, {(OUT_W-1){1'b1}}};
        neg_min = s2_uns ? '0 : {1'b1, {(OUT_W-1){1'b0}}};
        if (s2_uns)
            ovf = s2_big | (s2_mag > UMAX_MAG);
        else
            ovf = s2_big | (s2_sign ? (s2_mag > SMIN_MAG) : (s2_mag > SMAX_MAG));
        uneg = s2_uns & s2_sign & (s2_mag != '0);
        if (s2_nan)
            y_d = pos_max;
        else if (ovf)
            y_d = s2_sign ? neg_min : pos_max;
        else if (uneg)
            y_d = '0;
        else
            y_d = s2_sign ? -mag_lo : mag_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_sign   <= 1'b0;
            s1_int    <= '0;
            s1_g      <= 1'b0;
            s1_st     <= 1'b0;
            s1_rm     <= '0;
            s1_uns    <= 1'b0;
            s1_nan    <= 1'b0;
            s1_big    <= 1'b0;
            s1_tag    <= '0;
            s2_v      <= 1'b0;
            s2_sign   <= 1'b0;
            s2_mag    <= '0;
            s2_uns    <= 1'b0;
            s2_nan    <= 1'b0;
            s2_big    <= 1'b0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            s1_v      <= in_valid;
            s1_sign   <= sign_d;
            s1_int    <= int_d;
            s1_g      <= g_d;
            s1_st     <= st_d;
            s1_rm     <= in_rm;
            s1_uns    <= in_unsigned;
            s1_nan    <= nan_d;
            s1_big    <= big_d;
            s1_tag    <= in_tag;
            s2_v      <= s1_v;
            s2_sign   <= s1_sign;
            s2_mag    <= mag_d;
            s2_uns    <= s1_uns;
            s2_nan    <= s1_nan;
            s2_big    <= s1_big;
            s2_tag    <= s1_tag;
            out_valid <= s2_v;
            out_y     <= y_d;
            out_tag   <= s2_tag;
        end
    end

`ifdef FTOI_FLAGS_EN
    logic       s2_nx, nv;
    logic [1:0] flags_d, flags_q;

    always_comb begin
        nv      = s2_nan | ovf | uneg;
        flags_d = {nv, ~nv & s2_nx};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_nx   <= 1'b0;
            flags_q <= '0;
        end else if (advance) begin
            s2_nx   <= s1_g | s1_st;
            flags_q <= flags_d;
        end
    end

    assign out_flags = flags_q;
`else
    assign out_flags = 2'b00;
`endif

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed bench for ftoi_pipe: vector table on OUT_W=32/64 instances plus stall and reset sequences.
module tb_ftoi_pipe;
    logic        clk, rst;
    logic        in_valid, in_unsigned, out_ready;
    logic [31:0] in_x;
    logic [2:0]  in_rm;
    logic [4:0]  in_tag;

    logic        ir32, ov32, ir64, ov64;
    logic [31:0] y32;
    logic [63:0] y64;
    logic [1:0]  f32, f64;
    logic [4:0]  tag32, tag64;

    int passed = 0;
    int total  = 0;

    ftoi_pipe #(.OUT_W(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .in_x(in_x),
        .in_rm(in_rm), .in_unsigned(in_unsigned), .in_tag(in_tag), .out_valid(ov32),
        .out_ready(out_ready), .out_y(y32), .out_flags(f32), .out_tag(tag32)
    );

    ftoi_pipe #(.OUT_W(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64), .in_x(in_x),
        .in_rm(in_rm), .in_unsigned(in_unsigned), .in_tag(in_tag), .out_valid(ov64),
        .out_ready(out_ready), .out_y(y64), .out_flags(f64), .out_tag(tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [1:0] expf(input logic [1:0] f);
`ifdef FTOI_FLAGS_EN
        return f;
`else
        return 2'b00;
`endif
    endfunction

    typedef struct {
        logic [31:0] x;
        logic [2:0]  rm;
        logic        uns;
        logic        w64;
        logic [63:0] y;
        logic [1:0]  fl;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];
    logic [31:0] hvals [4];

    initial begin
        int lat;
        int got_n;
        int pend;
        int cnt;

        vecs[0]  = '{32'h40200000, 3'd0, 1'b0, 1'b0, 64'h2, 2'b01};
        vecs[1]  = '{32'h40200000, 3'd4, 1'b0, 1'b0, 64'h3, 2'b01};
        vecs[2]  = '{32'h40200000, 3'd1, 1'b0, 1'b0, 64'h2, 2'b01};
        vecs[3]  = '{32'hC0200000, 3'd2, 1'b0, 1'b0, 64'hFFFFFFFD, 2'b01};
        vecs[4]  = '{32'hC0200000, 3'd3, 1'b0, 1'b0, 64'hFFFFFFFE, 2'b01};
        vecs[5]  = '{32'hCF000000, 3'd0, 1'b0, 1'b0, 64'h80000000, 2'b00};
        vecs[6]  = '{32'h4F000000, 3'd0, 1'b0, 1'b0, 64'h7FFFFFFF, 2'b10};
        vecs[7]  = '{32'h7FC00000, 3'd0, 1'b0, 1'b0, 64'h7FFFFFFF, 2'b10};
        vecs[8]  = '{32'hFF800000, 3'd0, 1'b1, 1'b0, 64'h0, 2'b10};
        vecs[9]  = '{32'hBF800000, 3'd0, 1'b1, 1'b0, 64'h0, 2'b10};
        vecs[10] = '{32'hBE800000, 3'd1, 1'b1, 1'b0, 64'h0, 2'b01};
        vecs[11] = '{32'h4F800000, 3'd0, 1'b1, 1'b0, 64'hFFFFFFFF, 2'b10};
        vecs[12] = '{32'h40600000, 3'd0, 1'b0, 1'b0, 64'h4, 2'b01};
        vecs[13] = '{32'h40200000, 3'd7, 1'b0, 1'b0, 64'h2, 2'b01};
        vecs[14] = '{32'h00000000, 3'd0, 1'b0, 1'b0, 64'h0, 2'b00};
        vecs[15] = '{32'h00000001, 3'd3, 1'b0, 1'b0, 64'h1, 2'b01};
        vecs[16] = '{32'h53800000, 3'd0, 1'b0, 1'b1, 64'h0000010000000000, 2'b00};
        vecs[17] = '{32'h5F000000, 3'd0, 1'b0, 1'b1, 64'h7FFFFFFFFFFFFFFF, 2'b10};
        vecs[18] = '{32'h7FC00000, 3'd0, 1'b1, 1'b0, 64'hFFFFFFFF, 2'b10};
        hvals[0] = 32'h3F800000;
        hvals[1] = 32'h40000000;
        hvals[2] = 32'h40400000;
        hvals[3] = 32'h40800000;

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_rm = '0; in_unsigned = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(ov32), 64'(0));
        check("rst_out_y", 64'(y32), 64'(0));
        check("rst_out_flags", 64'(f32), 64'(0));
        check("rst_out_tag", 64'(tag32), 64'(0));
        check("rst_in_ready", 64'(ir32), 64'(1));

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_x = vecs[i].x; in_rm = vecs[i].rm;
            in_unsigned = vecs[i].uns; in_tag = 5'(i);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!ov32 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(3));
            check($sformatf("v%0d_tag", i), 64'(tag32), 64'(i));
            if (vecs[i].w64) begin
                check($sformatf("v%0d_y64", i), y64, vecs[i].y);
                check($sformatf("v%0d_flags64", i), 64'(f64), 64'(expf(vecs[i].fl)));
            end else begin
                check($sformatf("v%0d_y", i), 64'(y32), vecs[i].y);
                check($sformatf("v%0d_flags", i), 64'(f32), 64'(expf(vecs[i].fl)));
            end
        end

        // Four back-to-back ops against a consumer stalled for five cycles
        @(negedge clk);
        got_n = 0;
        pend = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = (c >= 8);
            if (pend < 4) begin
                in_valid = 1'b1; in_x = hvals[pend]; in_rm = 3'd0;
                in_unsigned = 1'b0; in_tag = 5'(pend + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 3 && c < 8) begin
                check($sformatf("stall%0d_in_ready", c), 64'(ir32), 64'(0));
                check($sformatf("stall%0d_out_valid", c), 64'(ov32), 64'(1));
                check($sformatf("stall%0d_tag", c), 64'(tag32), 64'(1));
                check($sformatf("stall%0d_y", c), 64'(y32), 64'(1));
            end
            if (ov32 && out_ready) begin
                check($sformatf("hs%0d_tag", got_n), 64'(tag32), 64'(got_n + 1));
                check($sformatf("hs%0d_y", got_n), 64'(y32), 64'(got_n + 1));
                got_n++;
            end
            if (in_valid && ir32) pend++;
        end
        in_valid = 1'b0;
        check("hs_count", 64'(got_n), 64'(4));

        // Reset while stalled drops everything in flight
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_x = hvals[k]; in_tag = 5'(k + 5);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_out_valid", 64'(ov32), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("rst_stall_out_valid", 64'(ov32), 64'(0));
        check("rst_stall_in_ready", 64'(ir32), 64'(1));
        rst = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ov32) cnt++;
        end
        check("post_rst_emerged", 64'(cnt), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
